// File: rtl/palette_pkg.sv
// -----------------------------------------------------------------------------
// palette_pkg
// Shared definitions for the palette loader, the palette slave and the pixel
// path.
//   pl_state_t        loader FSM state encoding
//   PAL_ENTRIES       number of 24-bit colour entries (8 palettes x 4 colours)
//   PAL_IDX_W         width of a palette entry index
//   PAL_CNT_W         width of an entry count able to hold 0..PAL_ENTRIES
//   PAL_BYTE_EN_RGB   byte enables covering the RGB bytes of a palette word
//   pal_palette()     palette number from an entry index (bits [4:2])
//   pal_colour()      colour slot from an entry index (bits [1:0])
//   pal_index()       entry index from a palette number and colour slot
// -----------------------------------------------------------------------------
package palette_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR      = 3'd3,
        FIN     = 3'd4
    } pl_state_t;

    localparam int PAL_ENTRIES = 32;
    localparam int PAL_IDX_W   = $clog2(PAL_ENTRIES);
    // One extra bit so that a full load of PAL_ENTRIES is representable.
    localparam int PAL_CNT_W   = PAL_IDX_W + 1;

    localparam logic [3:0] PAL_BYTE_EN_RGB = 4'b0111;

    function automatic logic [2:0] pal_palette(input logic [PAL_IDX_W-1:0] idx);
        return idx[4:2];
    endfunction

    function automatic logic [1:0] pal_colour(input logic [PAL_IDX_W-1:0] idx);
        return idx[1:0];
    endfunction

    function automatic logic [PAL_IDX_W-1:0] pal_index(input logic [2:0] palette,
                                                       input logic [1:0] colour);
        return {palette, colour};
    endfunction

endpackage : palette_pkg

// File: rtl/palette_loader.sv
// -----------------------------------------------------------------------------
// palette_loader
// Bulk-loads palette entries from system memory. Reads consecutive 32-bit
// words through an Avalon-MM read master (one read outstanding at a time) and
// writes the RGB part of each word into the palette slave's register file.
//
// Ports
//   CLK_100            system clock, rising edge
//   RESET              synchronous active-high reset, aborts any load
//   start              one-cycle load request, ignored unless idle
//   src_base           byte address of the first source word
//   first_index        first palette entry ([4:2] palette, [1:0] colour)
//   count              number of entries to load, 0..32
//   busy               load in progress (read/write phases)
//   done               one-cycle completion pulse
//   RD_ADDR/RD_READ    read-master request
//   RD_WAITREQUEST     read-slave stall
//   RD_READDATA        read data
//   RD_READDATAVALID   read data strobe
//   PAL_ADDR           palette entry address
//   PAL_WRITEDATA      {8'h00, RGB}
//   PAL_BYTE_EN        4'b0111 during a write, else 0
//   PAL_WRITE          palette write strobe
//   PAL_CS             palette chip select, mirrors PAL_WRITE
// -----------------------------------------------------------------------------
module palette_loader
    import palette_pkg::*;
#(
    parameter int SRC_AW = 32,
    parameter int STRIDE = 4
) (
    input  logic                 CLK_100,
    input  logic                 RESET,

    input  logic                 start,
    input  logic [SRC_AW-1:0]    src_base,
    input  logic [4:0]           first_index,
    input  logic [5:0]           count,
    output logic                 busy,
    output logic                 done,

    output logic [SRC_AW-1:0]    RD_ADDR,
    output logic                 RD_READ,
    input  logic                 RD_WAITREQUEST,
    input  logic [31:0]          RD_READDATA,
    input  logic                 RD_READDATAVALID,

    output logic [4:0]           PAL_ADDR,
    output logic [31:0]          PAL_WRITEDATA,
    output logic [3:0]           PAL_BYTE_EN,
    output logic                 PAL_WRITE,
    output logic                 PAL_CS
);

    localparam logic [SRC_AW-1:0] ADDR_STEP = SRC_AW'(STRIDE);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    pl_state_t              state_reg,  state_next;
    logic [SRC_AW-1:0]      addr_reg,   addr_next;
    logic [PAL_IDX_W-1:0]   entry_reg,  entry_next;
    logic [PAL_CNT_W-1:0]   remain_reg, remain_next;
    logic [23:0]            data_reg,   data_next;

    // Only the RGB bytes of the source word are used.
    logic unused_rd_hi;
    assign unused_rd_hi = ^RD_READDATA[31:24];

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK_100) begin
        if (RESET) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    // A zero-length load completes without touching either bus.
                    state_next = (count != '0) ? RD_REQ : FIN;
                end
            end
            RD_REQ: begin
                if (!RD_WAITREQUEST) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (RD_READDATAVALID) begin
                    state_next = WR;
                end
            end
            WR: begin
                // remain_reg still holds the pre-decrement value here.
                state_next = (remain_reg == PAL_CNT_W'(1)) ? FIN : RD_REQ;
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers: address, entry and remaining counters, read data
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK_100) begin
        if (RESET) begin
            addr_reg   <= '0;
            entry_reg  <= '0;
            remain_reg <= '0;
            data_reg   <= '0;
        end else begin
            addr_reg   <= addr_next;
            entry_reg  <= entry_next;
            remain_reg <= remain_next;
            data_reg   <= data_next;
        end
    end

    always_comb begin
        addr_next   = addr_reg;
        entry_next  = entry_reg;
        remain_next = remain_reg;
        data_next   = data_reg;
        unique case (state_reg)
            IDLE: begin
                if (start && (count != '0)) begin
                    addr_next   = src_base;
                    entry_next  = first_index;
                    remain_next = count;
                end
            end
            RD_WAIT: begin
                if (RD_READDATAVALID) begin
                    data_next = RD_READDATA[23:0];
                end
            end
            WR: begin
                // Entry index wraps 31->0 and the source address wraps at
                // 2^SRC_AW purely through the natural register widths.
                entry_next  = entry_reg + PAL_IDX_W'(1);
                addr_next   = addr_reg + ADDR_STEP;
                remain_next = remain_reg - PAL_CNT_W'(1);
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: every bus output is a pure function of the state so that
    // reset (which forces IDLE) immediately silences both masters.
    // -------------------------------------------------------------------------
    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        RD_READ       = 1'b0;
        RD_ADDR       = '0;
        PAL_WRITE     = 1'b0;
        PAL_CS        = 1'b0;
        PAL_ADDR      = '0;
        PAL_WRITEDATA = '0;
        PAL_BYTE_EN   = '0;
        unique case (state_reg)
            RD_REQ: begin
                busy    = 1'b1;
                RD_READ = 1'b1;
                RD_ADDR = addr_reg;
            end
            RD_WAIT: begin
                busy = 1'b1;
            end
            WR: begin
                busy          = 1'b1;
                PAL_WRITE     = 1'b1;
                PAL_CS        = 1'b1;
                PAL_ADDR      = entry_reg;
                PAL_WRITEDATA = {8'h00, data_reg};
                PAL_BYTE_EN   = PAL_BYTE_EN_RGB;
            end
            FIN: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule : palette_loader

// File: tb/tb_palette_loader.sv
// -----------------------------------------------------------------------------
// tb_palette_loader
// Self-checking bench for palette_loader: a memory/palette-side model runs on
// the falling edge, a table of directed loads plus random loads are compared
// against expectations built from the load parameters.
// -----------------------------------------------------------------------------
module tb_palette_loader;

    logic        CLK_100 = 1'b0;
    logic        RESET;
    logic        start;
    logic [31:0] src_base;
    logic [4:0]  first_index;
    logic [5:0]  count;
    logic        busy;
    logic        done;
    logic [31:0] RD_ADDR;
    logic        RD_READ;
    logic        RD_WAITREQUEST;
    logic [31:0] RD_READDATA;
    logic        RD_READDATAVALID;
    logic [4:0]  PAL_ADDR;
    logic [31:0] PAL_WRITEDATA;
    logic [3:0]  PAL_BYTE_EN;
    logic        PAL_WRITE;
    logic        PAL_CS;

    always #5 CLK_100 = ~CLK_100;

    palette_loader #(.SRC_AW(32), .STRIDE(4)) dut (
        .CLK_100          (CLK_100),
        .RESET            (RESET),
        .start            (start),
        .src_base         (src_base),
        .first_index      (first_index),
        .count            (count),
        .busy             (busy),
        .done             (done),
        .RD_ADDR          (RD_ADDR),
        .RD_READ          (RD_READ),
        .RD_WAITREQUEST   (RD_WAITREQUEST),
        .RD_READDATA      (RD_READDATA),
        .RD_READDATAVALID (RD_READDATAVALID),
        .PAL_ADDR         (PAL_ADDR),
        .PAL_WRITEDATA    (PAL_WRITEDATA),
        .PAL_BYTE_EN      (PAL_BYTE_EN),
        .PAL_WRITE        (PAL_WRITE),
        .PAL_CS           (PAL_CS)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Source memory contents: a few fixed words, a scrambled pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 32'hFF11_2233;
            32'h0000_1004: return 32'h0044_5566;
            32'h0000_1008: return 32'h0077_8899;
            32'h0000_100C: return 32'h00AA_BBCC;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        endcase
    endfunction

    // ---------------------------------------------------------------------
    // Bus-side model and monitor (falling edge)
    // ---------------------------------------------------------------------
    int          cyc = 0;
    logic [31:0] rd_addr_q[$];
    logic [4:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          rd_n, done_count, done_cyc, busy_cycles, busy_at_done;
    int          resp_delay = 0;
    logic [31:0] resp_data;
    int          cur_lat, stall_idx, stall_len, stall_cnt;
    bit          rnd_mode;
    bit          prev_stalled = 1'b0;
    logic [31:0] prev_addr;

    initial begin
        RD_WAITREQUEST   = 1'b0;
        RD_READDATAVALID = 1'b0;
        RD_READDATA      = '0;
        rd_n = 0; done_count = 0; busy_cycles = 0; stall_cnt = 0;
        cur_lat = 1; stall_idx = -1; stall_len = 0; rnd_mode = 1'b0;
        forever begin
            @(negedge CLK_100);
            cyc++;
            if (PAL_WRITE) begin
                chk("pal_cs", PAL_CS, 1);
                chk("pal_byte_en", PAL_BYTE_EN, 4'b0111);
                wr_addr_q.push_back(PAL_ADDR);
                wr_data_q.push_back(PAL_WRITEDATA);
            end else begin
                chk("pal_cs_idle", PAL_CS, 0);
                chk("pal_byte_en_idle", PAL_BYTE_EN, 0);
            end
            if (busy) busy_cycles++;
            if (done) begin
                done_count++;
                done_cyc     = cyc;
                busy_at_done = busy_cycles;
                chk("busy_in_fin", busy, 0);
            end
            // Read data return
            RD_READDATAVALID = 1'b0;
            RD_READDATA      = $urandom;
            if (resp_delay > 0) begin
                resp_delay--;
                if (resp_delay == 0) begin
                    RD_READDATAVALID = 1'b1;
                    RD_READDATA      = resp_data;
                end
            end
            // Request must be held while stalled
            if (prev_stalled) begin
                chk("rd_read_hold", RD_READ, 1);
                chk("rd_addr_hold", RD_ADDR, prev_addr);
            end
            if (RD_READ && stall_cnt > 0) begin
                RD_WAITREQUEST = 1'b1;
                stall_cnt--;
            end else begin
                RD_WAITREQUEST = rnd_mode ? 1'($urandom_range(0, 1) & ~RD_READ) : 1'b0;
            end
            prev_stalled = RD_READ && RD_WAITREQUEST;
            prev_addr    = RD_ADDR;
            if (RD_READ && !RD_WAITREQUEST) begin
                rd_addr_q.push_back(RD_ADDR);
                resp_data  = mem_word(RD_ADDR);
                resp_delay = rnd_mode ? int'($urandom_range(1, 3)) : cur_lat;
                rd_n++;
                if (rd_n == stall_idx)  stall_cnt = stall_len;
                else if (rnd_mode)      stall_cnt = int'($urandom_range(0, 2));
                else                    stall_cnt = 0;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Directed load table
    // ---------------------------------------------------------------------
    typedef struct {
        logic [31:0] base;
        logic [4:0]  first;
        logic [5:0]  cnt;
        int          lat;      // read latency in cycles
        int          sidx;     // read number (0-based) that is stalled
        int          slen;     // stall length
        int          poke;     // cycle after start at which a stray start is pulsed
        int          exp_cyc;  // expected start-to-done cycles, -1 = unchecked
    } vec_t;

    vec_t vecs[7];

    task automatic run_load(input string tag, input logic [31:0] base, input logic [4:0] first,
                            input logic [5:0] cnt, input int lat, input int sidx, input int slen,
                            input bit rnd, input int poke, input int exp_cyc);
        logic [31:0] exp_rd[$];
        logic [4:0]  exp_wa[$];
        logic [31:0] exp_wd[$];
        logic [31:0] a, w;
        int          start_cyc, lat_seen;
        bit          got;
        for (int i = 0; i < int'(cnt); i++) begin
            a = base + 32'(4 * i);
            w = mem_word(a);
            exp_rd.push_back(a);
            exp_wa.push_back(5'((int'(first) + i) % 32));
            exp_wd.push_back({8'h00, w[23:0]});
        end
        @(negedge CLK_100);
        #1;
        rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
        rd_n = 0; done_count = 0; busy_cycles = 0;
        cur_lat = lat; stall_idx = sidx; stall_len = slen; rnd_mode = rnd;
        stall_cnt = (sidx == 0) ? slen : 0;
        start = 1'b1; src_base = base; first_index = first; count = cnt;
        @(posedge CLK_100);
        start_cyc = cyc;
        got = 1'b0;
        for (int k = 1; k <= 3000 && !got; k++) begin
            @(negedge CLK_100);
            #1;
            start = (k == poke);
            if (start) begin
                src_base = $urandom; first_index = 5'($urandom); count = 6'($urandom_range(1, 32));
            end
            if (done_count > 0) got = 1'b1;
        end
        @(negedge CLK_100);
        #1;
        start = 1'b0;
        chk({tag, "_done_seen"}, got, 1);
        lat_seen = done_cyc - start_cyc;
        if (got && exp_cyc >= 0) chk({tag, "_done_latency"}, lat_seen, exp_cyc);
        if (got) chk({tag, "_busy_cycles"}, busy_at_done, lat_seen - 1);
        repeat (20) @(negedge CLK_100);
        #1;
        chk({tag, "_done_count"}, done_count, 1);
        chk({tag, "_reads"}, rd_addr_q.size(), cnt);
        chk({tag, "_writes"}, wr_addr_q.size(), cnt);
        for (int i = 0; i < exp_rd.size() && i < rd_addr_q.size(); i++)
            chk($sformatf("%s_rd_addr%0d", tag, i), rd_addr_q[i], exp_rd[i]);
        for (int i = 0; i < exp_wa.size() && i < wr_addr_q.size(); i++) begin
            chk($sformatf("%s_wr_addr%0d", tag, i), wr_addr_q[i], exp_wa[i]);
            chk($sformatf("%s_wr_data%0d", tag, i), wr_data_q[i], exp_wd[i]);
        end
        $display("load %s base=%08h first=%0d count=%0d reads=%0d writes=%0d done_lat=%0d",
                 tag, base, first, cnt, rd_addr_q.size(), wr_addr_q.size(), lat_seen);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_read"}, RD_READ, 0);
        chk({tag, "_rd_addr"}, RD_ADDR, 0);
        chk({tag, "_pal_write"}, PAL_WRITE, 0);
        chk({tag, "_pal_addr"}, PAL_ADDR, 0);
        chk({tag, "_pal_wdata"}, PAL_WRITEDATA, 0);
    endtask

    // ---------------------------------------------------------------------
    // Main sequence
    // ---------------------------------------------------------------------
    initial begin
        bit got;
        RESET = 1'b1; start = 1'b0; src_base = '0; first_index = '0; count = '0;

        //            base          first  cnt  lat sidx slen poke exp
        vecs[0] = '{32'h0000_1000, 5'd0,  6'd4,  1, -1, 0, -1, 13};  // basic
        vecs[1] = '{32'h0000_2000, 5'd30, 6'd4,  1, -1, 0, -1, 13};  // index wrap
        vecs[2] = '{32'h0000_3000, 5'd5,  6'd4,  1,  1, 5, -1, 18};  // stall 2nd read
        vecs[3] = '{32'h0000_4000, 5'd7,  6'd0,  1, -1, 0, -1, 1};   // empty load
        vecs[4] = '{32'h0000_5000, 5'd2,  6'd8,  1, -1, 0, 10, 25};  // start mid-load
        vecs[5] = '{32'h0000_6000, 5'd9,  6'd32, 1, -1, 0, 97, 97};  // full, start in FIN
        vecs[6] = '{32'hFFFF_FFF8, 5'd3,  6'd4,  2, -1, 0, -1, 17};  // address wrap

        repeat (3) @(negedge CLK_100);
        check_idle_outputs("reset");
        #1;
        RESET = 1'b0;
        repeat (100) @(negedge CLK_100);
        #1;
        chk("idle_reads", rd_n, 0);
        chk("idle_writes", wr_addr_q.size(), 0);
        chk("idle_done", done_count, 0);
        check_idle_outputs("idle");

        for (int v = 0; v < 7; v++)
            run_load($sformatf("vec%0d", v), vecs[v].base, vecs[v].first, vecs[v].cnt,
                     vecs[v].lat, vecs[v].sidx, vecs[v].slen, 1'b0, vecs[v].poke, vecs[v].exp_cyc);

        // Reset while waiting for the third read's data of an 8-entry load.
        @(negedge CLK_100);
        #1;
        rd_addr_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
        rd_n = 0; done_count = 0; busy_cycles = 0;
        cur_lat = 4; stall_idx = -1; stall_len = 0; stall_cnt = 0; rnd_mode = 1'b0;
        start = 1'b1; src_base = 32'h0000_7000; first_index = 5'd0; count = 6'd8;
        @(negedge CLK_100);
        #1;
        start = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge CLK_100);
            #1;
            if (rd_n == 3) got = 1'b1;
        end
        chk("rst_third_read", got, 1);
        @(negedge CLK_100);
        #1;
        chk("rst_pre_busy", busy, 1);
        chk("rst_pre_rd_read", RD_READ, 0);
        RESET = 1'b1;
        @(negedge CLK_100);
        #1;
        check_idle_outputs("rst_abort");
        RESET = 1'b0;
        repeat (15) @(negedge CLK_100);
        #1;
        chk("rst_writes", wr_addr_q.size(), 2);
        chk("rst_reads", rd_n, 3);
        chk("rst_no_done", done_count, 0);
        $display("load reset_abort base=00007000 count=8 reads=%0d writes=%0d done=%0d",
                 rd_n, wr_addr_q.size(), done_count);

        // Random loads with random stalls and read latency.
        for (int r = 0; r < 10; r++)
            run_load($sformatf("rnd%0d", r), $urandom, 5'($urandom), 6'($urandom_range(0, 32)),
                     1, -1, 0, 1'b1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_palette_loader

// File: doc/palette_loader.md
Name: palette_loader

Overview:
- Avalon-MM master that bulk-loads the 8x4 24-bit colour palette from system memory.
- Reads N consecutive 32-bit words from a source buffer through a read master.
- Writes each word to the palette slave's register file through a write master.
- Used for palette swaps and fades between frames without CPU word-by-word writes; sits between the SDRAM interconnect and the palette slave.

Parameters:
- SRC_AW, 32, source byte-address width.
- STRIDE, 4, byte increment between source words.

Ports:
- CLK_100  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a load; ignored while busy.
- src_base  in  SRC_AW  byte address of the first source word; sampled on accepted start.
- first_index  in  5  first palette entry; [4:2] is the palette, [1:0] is the colour; sampled on start.
- count  in  6  number of entries to load, 0..32; sampled on start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the load completes.
- RD_ADDR  out  SRC_AW  read-master address.
- RD_READ  out  1  read-master request.
- RD_WAITREQUEST  in  1  slave stall.
- RD_READDATA  in  32  returned data.
- RD_READDATAVALID  in  1  data-valid strobe.
- PAL_ADDR  out  5  palette address.
- PAL_WRITEDATA  out  32  bits [23:0] are RGB; bits [31:24] are driven 0.
- PAL_BYTE_EN  out  4  constant 4'b0111 while writing, else 0.
- PAL_WRITE  out  1  palette write strobe.
- PAL_CS  out  1  palette chip select; equals PAL_WRITE.

Behaviour:
- Reset values: busy=0, done=0, RD_READ=0, RD_ADDR=0, PAL_WRITE=0, PAL_CS=0, PAL_ADDR=0, PAL_WRITEDATA=0, PAL_BYTE_EN=0. FSM returns to IDLE.
- Reset asserted mid-load aborts immediately. No further bus activity occurs, and no done pulse is generated.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR, FIN.
- IDLE:
  - On start with count>0, latch src_base to the address counter, first_index to the entry counter, and count to the remaining counter, then go to RD_REQ.
  - On start with count==0, go to FIN; no bus traffic occurs.
- RD_REQ:
  - Assert RD_READ with RD_ADDR equal to the address counter.
  - Hold RD_READ and RD_ADDR stable while RD_WAITREQUEST=1.
  - In the first cycle with RD_WAITREQUEST=0, the request is accepted; deassert RD_READ next cycle and go to RD_WAIT.
- RD_WAIT:
  - Only one read is outstanding at a time.
  - On RD_READDATAVALID, capture RD_READDATA[23:0] and go to WR.
  - RD_READDATAVALID outside RD_WAIT is ignored.
- WR:
  - Drive PAL_WRITE=1, PAL_CS=1, PAL_ADDR=entry counter, PAL_WRITEDATA={8'h00, captured[23:0]}, PAL_BYTE_EN=4'b0111, for exactly one cycle.
  - The palette slave has no waitrequest; the write completes in that cycle.
  - Then increment the entry counter (5-bit, wraps 31->0), add STRIDE to the address counter (wraps at 2^SRC_AW), and decrement the remaining counter.
  - If remaining becomes 0, go to FIN; else go to RD_REQ.
- FIN: done=1 for one cycle, busy=0 in the same cycle, then IDLE.
- busy is 1 in RD_REQ, RD_WAIT and WR; it is 0 in IDLE and FIN.
- start arriving in FIN or in any busy state is dropped; it is neither queued nor restarted.
- A start in the cycle after FIN, i.e. in IDLE, is accepted.
- count values above 32 are unrepresentable (6-bit field, 32 maximum). count=32 with any first_index rewrites every palette entry exactly once, in wrap order.
- Minimum per-entry latency: 3 cycles (RD_REQ accept, RD_WAIT with same-next-cycle valid, WR).
- Total minimum latency from start to done: 3*count+1 cycles after the start edge.

Decomposition:
- Package palette_pkg holds:
  - state enum pl_state_t;
  - constant PAL_ENTRIES=32;
  - constant PAL_BYTE_EN_RGB=4'b0111;
  - address-split helpers for palette [4:2] and colour [1:0], shared with the palette slave and the pixel path.
- No sub-module: FSM, counters and data register in one module.

Test Plan:
- Reset then idle, no start -> all outputs 0 and no RD_READ or PAL_WRITE for 100 cycles.
- start, src_base=0x1000, first_index=0, count=4; memory returns 0xFF112233, 0x00445566, 0x00778899, 0x00AABBCC with 1-cycle latency -> reads at 0x1000/04/08/0C; PAL writes addr 0..3 with data 0x00112233, 0x00445566, 0x00778899, 0x00AABBCC, byte_en 0111; done pulse at cycle 13 after start.
- first_index=30, count=4 -> PAL_ADDR sequence 30, 31, 0, 1; done once.
- RD_WAITREQUEST held high for 5 cycles on the second read -> RD_ADDR and RD_READ stable throughout; exactly one read is accepted; there is no duplicate write.
- count=0 -> done pulses the cycle after start, busy never rises, no bus activity. A start pulsed mid-load is ignored, so total writes equal the original count.
- RESET asserted while in RD_WAIT on entry 2 of 8 -> next cycle all outputs are at reset values, no done, and a stale RD_READDATAVALID afterwards causes no write.
